tmr_fault_voter: RTL and testbench

//   Registered, parametrised N-way bitwise majority voter with per-voter fault tracking.

---
 rtl/voter_pkg.sv | 37 +++
 rtl/voter_health_cnt.sv | 42 ++++
 rtl/tmr_fault_voter.sv | 83 ++++++++
 tb/tb_tmr_fault_voter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared types and helpers for the TMR fault voter: population count,
// counter sizing and the per-bit majority decision.
package voter_pkg;

    localparam int MAX_VOTERS = 15;
    localparam int PC_W       = 5;

    typedef struct packed {
        logic tie;
        logic val;
    } maj_t;

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_VOTERS:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i <= MAX_VOTERS; i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    function automatic int cnt_width(input int thresh);
        return $clog2(thresh + 1);
    endfunction

    // Compare 2*ones against the active count so even quorums can tie.
    function automatic maj_t maj_bit(input logic [PC_W-1:0] ones,
                                     input logic [PC_W-1:0] active);
        maj_t m;
        logic [PC_W:0] twice;
        logic [PC_W:0] act;
        twice = {ones, 1'b0};
        act   = {1'b0, active};
        m.val = (twice > act);
        m.tie = (twice == act);
        return m;
    endfunction

endpackage

// File: rtl/voter_health_cnt.sv
// Per-voter consecutive-disagreement counter with a sticky mask bit.
module voter_health_cnt
    import voter_pkg::*;
#(
    parameter int FAULT_THRESH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic disagree,
    input  logic clear,
    output logic masked,
    output logic newly_masked
);

    localparam int CNT_W = cnt_width(FAULT_THRESH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FAULT_THRESH - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(FAULT_THRESH);

    logic [CNT_W-1:0] cnt;

    // Clear wins over the health update of a coincident sample.
    assign newly_masked = en & ~clear & ~masked & disagree & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            masked <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            masked <= 1'b0;
        end else if (en && !masked) begin
            if (disagree) begin
                if (cnt != SAT) cnt <= cnt + 1'b1;
                if (cnt == LAST) masked <= 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tmr_fault_voter.sv
// Registered N-way bitwise majority voter; voters that keep disagreeing
// with the result are masked out and the quorum shrinks accordingly.
module tmr_fault_voter
    import voter_pkg::*;
#(
    parameter int N_VOTERS     = 5,
    parameter int W            = 4,
    parameter int FAULT_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [N_VOTERS*W-1:0] votes,
    input  logic                  clear_faults,
    output logic                  out_valid,
    output logic [W-1:0]          result,
    output logic [W-1:0]          tie,
    output logic                  no_quorum,
    output logic [N_VOTERS-1:0]   disagree,
    output logic [N_VOTERS-1:0]   fault_mask,
    output logic                  fault_new
);

    logic [N_VOTERS-1:0] active;
    logic [N_VOTERS-1:0] newly;
    logic [N_VOTERS-1:0] dis_c;
    logic [W-1:0]        res_c;
    logic [W-1:0]        tie_c;
    logic [PC_W-1:0]     act_cnt;
    logic                quorum;

    assign active  = ~fault_mask;
    assign act_cnt = popcount(16'(active));
    assign quorum  = (act_cnt != '0);

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [N_VOTERS-1:0] col;
        maj_t                m;
        always_comb begin
            col = '0;
            for (int i = 0; i < N_VOTERS; i++) col[i] = votes[i*W + b] & active[i];
        end
        assign m        = maj_bit(popcount(16'(col)), act_cnt);
        assign res_c[b] = quorum & m.val;
        assign tie_c[b] = quorum & m.tie;
    end

    for (genvar i = 0; i < N_VOTERS; i++) begin : g_voter
        // Tied bits carry no verdict, so they are excluded from disagreement.
        assign dis_c[i] = quorum & active[i] & (|((votes[i*W +: W] ^ res_c) & ~tie_c));

        voter_health_cnt #(.FAULT_THRESH(FAULT_THRESH)) u_health (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (in_valid & quorum),
            .disagree     (dis_c[i]),
            .clear        (clear_faults),
            .masked       (fault_mask[i]),
            .newly_masked (newly[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            tie       <= '0;
            no_quorum <= 1'b0;
            disagree  <= '0;
            fault_new <= 1'b0;
        end else begin
            out_valid <= in_valid;
            fault_new <= |newly;
            if (in_valid) begin
                result    <= res_c;
                tie       <= tie_c;
                no_quorum <= ~quorum;
                disagree  <= dis_c;
            end
        end
    end

endmodule

// File: tb/tb_tmr_fault_voter.sv
// Directed bench for tmr_fault_voter with N=5, W=4, FAULT_THRESH=3.
module tb_tmr_fault_voter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] votes;
    logic        clear_faults;
    logic        out_valid;
    logic [3:0]  result;
    logic [3:0]  tie;
    logic        no_quorum;
    logic [4:0]  disagree;
    logic [4:0]  fault_mask;
    logic        fault_new;

    int vectors = 0;
    int miscompares = 0;

    tmr_fault_voter #(.N_VOTERS(5), .W(4), .FAULT_THRESH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .votes        (votes),
        .clear_faults (clear_faults),
        .out_valid    (out_valid),
        .result       (result),
        .tie          (tie),
        .no_quorum    (no_quorum),
        .disagree     (disagree),
        .fault_mask   (fault_mask),
        .fault_new    (fault_new)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] vv(input logic [3:0] v0, v1, v2, v3, v4);
        return {v4, v3, v2, v1, v0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [19:0] vt, input logic clr);
        @(negedge clk);
        in_valid     = v;
        votes        = vt;
        clear_faults = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [3:0] r,
                           input logic [3:0] t, input logic nq, input logic [4:0] d,
                           input logic [4:0] m, input logic fn);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".result"},    32'(result),    32'(r));
        chk({tag, ".tie"},       32'(tie),       32'(t));
        chk({tag, ".no_quorum"}, 32'(no_quorum), 32'(nq));
        chk({tag, ".disagree"},  32'(disagree),  32'(d));
        chk({tag, ".mask"},      32'(fault_mask), 32'(m));
        chk({tag, ".fault_new"}, 32'(fault_new), 32'(fn));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; votes = '0; clear_faults = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 0, 4'h0, 4'h0, 0, 5'b00000, 5'b00000, 0);

        @(negedge clk);
        rst_n = 1'b1;
        step(1, vv(4'hA, 4'hA, 4'hA, 4'hA, 4'hA), 0);
        chk_out("unanimous", 1, 4'hA, 4'h0, 0, 5'b00000, 5'b00000, 0);

        // voter2 disagrees three times in a row and is masked on the third
        step(1, vv(4'hA, 4'hA, 4'h5, 4'hA, 4'hA), 0);
        chk_out("dis1", 1, 4'hA, 4'h0, 0, 5'b00100, 5'b00000, 0);
        step(1, vv(4'hA, 4'hA, 4'h5, 4'hA, 4'hA), 0);
        chk_out("dis2", 1, 4'hA, 4'h0, 0, 5'b00100, 5'b00000, 0);
        step(1, vv(4'hA, 4'hA, 4'h5, 4'hA, 4'hA), 0);
        chk_out("dis3", 1, 4'hA, 4'h0, 0, 5'b00100, 5'b00100, 1);

        step(0, vv(4'h0, 4'h0, 4'h0, 4'h0, 4'h0), 0);
        chk_out("idle_hold", 0, 4'hA, 4'h0, 0, 5'b00100, 5'b00100, 0);

        step(1, vv(4'hA, 4'hA, 4'h5, 4'hA, 4'hA), 0);
        chk_out("dis4_masked", 1, 4'hA, 4'h0, 0, 5'b00000, 5'b00100, 0);

        step(1, vv(4'hF, 4'hF, 4'h5, 4'h0, 4'h0), 0);
        chk_out("even_tie", 1, 4'h0, 4'hF, 0, 5'b00000, 5'b00100, 0);

        // voter1: 2 disagree, 1 agree, 2 disagree -> still active
        step(1, vv(4'hA, 4'h5, 4'hA, 4'hA, 4'hA), 0);
        chk_out("v1_d1", 1, 4'hA, 4'h0, 0, 5'b00010, 5'b00100, 0);
        step(1, vv(4'hA, 4'h5, 4'hA, 4'hA, 4'hA), 0);
        chk_out("v1_d2", 1, 4'hA, 4'h0, 0, 5'b00010, 5'b00100, 0);
        step(1, vv(4'hA, 4'hA, 4'hA, 4'hA, 4'hA), 0);
        chk_out("v1_agree", 1, 4'hA, 4'h0, 0, 5'b00000, 5'b00100, 0);
        step(1, vv(4'hA, 4'h5, 4'hA, 4'hA, 4'hA), 0);
        chk_out("v1_d3", 1, 4'hA, 4'h0, 0, 5'b00010, 5'b00100, 0);
        step(1, vv(4'hA, 4'h5, 4'hA, 4'hA, 4'hA), 0);
        chk_out("v1_d4", 1, 4'hA, 4'h0, 0, 5'b00010, 5'b00100, 0);
        // a third consecutive disagreement after the reset finally masks it
        step(1, vv(4'hA, 4'h5, 4'hA, 4'hA, 4'hA), 0);
        chk_out("v1_d5", 1, 4'hA, 4'h0, 0, 5'b00010, 5'b00110, 1);

        // remaining three voters each hold a lone bit, so all three disagree
        step(1, vv(4'h1, 4'hF, 4'hF, 4'h2, 4'h4), 0);
        chk_out("all_d1", 1, 4'h0, 4'h0, 0, 5'b11001, 5'b00110, 0);
        step(1, vv(4'h1, 4'hF, 4'hF, 4'h2, 4'h4), 0);
        chk_out("all_d2", 1, 4'h0, 4'h0, 0, 5'b11001, 5'b00110, 0);
        step(1, vv(4'h1, 4'hF, 4'hF, 4'h2, 4'h4), 0);
        chk_out("all_d3", 1, 4'h0, 4'h0, 0, 5'b11001, 5'b11111, 1);

        step(1, vv(4'hF, 4'hF, 4'hF, 4'hF, 4'hF), 0);
        chk_out("no_quorum", 1, 4'h0, 4'h0, 1, 5'b00000, 5'b11111, 0);

        step(1, vv(4'hF, 4'hF, 4'hF, 4'hF, 4'hF), 1);
        chk_out("clear_nq", 1, 4'h0, 4'h0, 1, 5'b00000, 5'b00000, 0);

        step(1, vv(4'h3, 4'h3, 4'h3, 4'h3, 4'h3), 0);
        chk_out("post_clear", 1, 4'h3, 4'h0, 0, 5'b00000, 5'b00000, 0);

        // clear coinciding with a sample that would otherwise complete a fault
        step(1, vv(4'h3, 4'h3, 4'hC, 4'h3, 4'h3), 0);
        step(1, vv(4'h3, 4'h3, 4'hC, 4'h3, 4'h3), 0);
        step(1, vv(4'h3, 4'h3, 4'hC, 4'h3, 4'h3), 1);
        chk_out("clear_prio", 1, 4'h3, 4'h0, 0, 5'b00100, 5'b00000, 0);

        // mask voter2 again, then reset between back-to-back samples
        step(1, vv(4'h3, 4'h3, 4'hC, 4'h3, 4'h3), 0);
        step(1, vv(4'h3, 4'h3, 4'hC, 4'h3, 4'h3), 0);
        step(1, vv(4'h3, 4'h3, 4'hC, 4'h3, 4'h3), 0);
        chk_out("premask", 1, 4'h3, 4'h0, 0, 5'b00100, 5'b00100, 1);
        @(negedge clk);
        in_valid = 1'b1;
        votes    = vv(4'h9, 4'h9, 4'h9, 4'h9, 4'h9);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_out("async_rst", 0, 4'h0, 4'h0, 0, 5'b00000, 5'b00000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_out("after_rst", 0, 4'h0, 4'h0, 0, 5'b00000, 5'b00000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
